// File: rtl/alarm_pkg.sv
// Shared types and limits for the time-of-day / alarm block.
package alarm_pkg;

  localparam int HH_W = 5;
  localparam int MS_W = 6;

  localparam logic [HH_W-1:0] HH_MAX = 5'd23;
  localparam logic [MS_W-1:0] MS_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  // True when a requested time is a legal time of day.
  function automatic logic set_in_range(input logic [HH_W-1:0] h,
                                        input logic [MS_W-1:0] m,
                                        input logic [MS_W-1:0] s);
    return (h <= HH_MAX) && (m <= MS_MAX) && (s <= MS_MAX);
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchroniser for the asynchronous seconds square wave, followed by
// a rising-edge detector producing a one-cycle tick.
module tick_sync
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sec_in,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sec_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Rising edges only; a level held high yields a single tick.
  assign tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds counter with time-set commands and an alarm
// ringing/snooze state machine driven by the synchronised seconds tick.
module time_keeper
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sec_in,
  input  logic            set_valid,
  input  logic [HH_W-1:0] set_hh,
  input  logic [MS_W-1:0] set_mm,
  input  logic [MS_W-1:0] set_ss,
  input  logic            alarm_en,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MS_W-1:0] alarm_mm,
  input  logic            alarm_ack,
  input  logic            snooze,
  output logic [HH_W-1:0] hh,
  output logic [MS_W-1:0] mm,
  output logic [MS_W-1:0] ss,
  output logic            tick,
  output logic            set_err,
  output logic            alarm_out
);

  localparam int CNT_W = $clog2((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC) + 1;
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  logic            w_tick;
  logic            w_tick_eff;
  logic            w_match;
  logic            w_set_ok;

  logic            r_set_valid;
  logic [HH_W-1:0] r_set_hh;
  logic [MS_W-1:0] r_set_mm;
  logic [MS_W-1:0] r_set_ss;

  logic [HH_W-1:0] r_hh;
  logic [MS_W-1:0] r_mm;
  logic [MS_W-1:0] r_ss;
  logic            r_set_err;

  logic [HH_W-1:0] w_hh_inc;
  logic [MS_W-1:0] w_mm_inc;
  logic [MS_W-1:0] w_ss_inc;

  alarm_state_t    r_state;
  alarm_state_t    w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  tick_sync u_tick_sync (
    .clk    (clk),
    .rst    (rst),
    .sec_in (sec_in),
    .tick   (w_tick)
  );

  // A tick landing in the cycle a set command is applied is swallowed.
  assign w_tick_eff = w_tick & ~r_set_valid;
  assign w_set_ok   = set_in_range(r_set_hh, r_set_mm, r_set_ss);

  // Capture the set command so the load/reject happens one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_valid <= 1'b0;
      r_set_hh    <= '0;
      r_set_mm    <= '0;
      r_set_ss    <= '0;
    end else begin
      r_set_valid <= set_valid;
      r_set_hh    <= set_hh;
      r_set_mm    <= set_mm;
      r_set_ss    <= set_ss;
    end
  end

  // Time of day one second ahead, with cascaded wrap at 59/59/23.
  always_comb begin
    w_ss_inc = r_ss + 1'b1;
    w_mm_inc = r_mm;
    w_hh_inc = r_hh;
    if (r_ss == MS_MAX) begin
      w_ss_inc = '0;
      if (r_mm == MS_MAX) begin
        w_mm_inc = '0;
        w_hh_inc = (r_hh == HH_MAX) ? '0 : r_hh + 1'b1;
      end else begin
        w_mm_inc = r_mm + 1'b1;
      end
    end
  end

  // Time registers: set command wins over the seconds tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hh      <= '0;
      r_mm      <= '0;
      r_ss      <= '0;
      r_set_err <= 1'b0;
    end else begin
      r_set_err <= 1'b0;
      if (r_set_valid) begin
        if (w_set_ok) begin
          r_hh <= r_set_hh;
          r_mm <= r_set_mm;
          r_ss <= r_set_ss;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (w_tick) begin
        r_hh <= w_hh_inc;
        r_mm <= w_mm_inc;
        r_ss <= w_ss_inc;
      end
    end
  end

  // Only a real increment can reach the alarm time; a set never triggers it.
  assign w_match = w_tick_eff & alarm_en & (w_hh_inc == alarm_hh) &
                   (w_mm_inc == alarm_mm) & (w_ss_inc == '0);

  // Alarm state and ring/snooze second counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state; disarming overrides every other condition.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_match) w_state_next = RINGING;
      end
      RINGING: begin
        if (alarm_ack)                           w_state_next = IDLE;
        else if (snooze)                         w_state_next = SNOOZE;
        else if (w_tick && (r_cnt == RING_LAST)) w_state_next = IDLE;
      end
      SNOOZE: begin
        if (w_tick && (r_cnt == SNOOZE_LAST)) w_state_next = RINGING;
      end
      default: w_state_next = IDLE;
    endcase
    if (!alarm_en) w_state_next = IDLE;
  end

  // Counter restarts on every state entry and counts ticks while active.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if ((r_state != IDLE) && w_tick) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Buzzer drive follows the RINGING state directly.
  always_comb begin
    alarm_out = (r_state == RINGING);
  end

  assign hh      = r_hh;
  assign mm      = r_mm;
  assign ss      = r_ss;
  assign tick    = w_tick;
  assign set_err = r_set_err;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_in;
  logic       set_valid;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       alarm_en;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_ack;
  logic       snooze;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       tick;
  logic       set_err;
  logic       alarm_out;

  logic [31:0] cur;
  int n_assert = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int t0;

  assign cur = {15'd0, hh, mm, ss};

  time_keeper #(.RING_SEC(60), .SNOOZE_SEC(300)) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_in    (sec_in),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .alarm_en  (alarm_en),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_ack (alarm_ack),
    .snooze    (snooze),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .tick      (tick),
    .set_err   (set_err),
    .alarm_out (alarm_out)
  );

  always #5 clk = ~clk;

  // Count tick pulses mid-cycle, where tick is stable.
  always @(negedge clk) if (tick === 1'b1) tick_cnt++;

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    logic [4:0] hv;
    logic [5:0] mv;
    logic [5:0] sv;
    hv = 5'(h);
    mv = 6'(m);
    sv = 6'(s);
    return {15'd0, hv, mv, sv};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic sec_pulse();
    sec_in = 1'b1;
    step(4);
    sec_in = 1'b0;
    step(4);
  endtask

  task automatic pulses(input int n);
    repeat (n) sec_pulse();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_hh    = 5'(h);
    set_mm    = 6'(m);
    set_ss    = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; sec_in = 1'b0; set_valid = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0;
    alarm_en = 1'b0; alarm_hh = '0; alarm_mm = '0;
    alarm_ack = 1'b0; snooze = 1'b0;
    step(3);
    chk("rst_time",    cur, 32'd0);
    chk("rst_tick",    32'(tick), 32'd0);
    chk("rst_set_err", 32'(set_err), 32'd0);
    chk("rst_alarm",   32'(alarm_out), 32'd0);
    rst = 1'b0;
    step(2);

    // First seconds edge: tick one cycle after sync, ss two edges after sync1.
    t0 = tick_cnt;
    sec_in = 1'b1;
    step();
    chk("lat_k_tick",  32'(tick), 32'd0);
    step();
    chk("lat_k1_tick", 32'(tick), 32'd1);
    chk("lat_k1_ss",   32'(ss), 32'd0);
    step();
    chk("lat_k2_tick", 32'(tick), 32'd0);
    chk("lat_k2_ss",   32'(ss), 32'd1);
    step();
    sec_in = 1'b0;
    step(4);
    pulses(2);
    chk("three_sec", cur, hms(0, 0, 3));
    chk("three_ticks", 32'(tick_cnt - t0), 32'd3);

    // Set latency and wrap through midnight.
    set_hh = 5'd23; set_mm = 6'd59; set_ss = 6'd58; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("set_not_yet", cur, hms(0, 0, 3));
    step();
    chk("set_load", cur, hms(23, 59, 58));
    sec_pulse();
    chk("wrap_59", cur, hms(23, 59, 59));
    sec_pulse();
    chk("wrap_midnight", cur, hms(0, 0, 0));

    // Out-of-range set commands.
    set_hh = 5'd24; set_mm = 6'd10; set_ss = 6'd10; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("bad_hh_err_n", 32'(set_err), 32'd0);
    step();
    chk("bad_hh_err", 32'(set_err), 32'd1);
    chk("bad_hh_time", cur, hms(0, 0, 0));
    step();
    chk("bad_hh_err_off", 32'(set_err), 32'd0);
    set_time(5, 60, 0);
    chk("bad_mm_err", 32'(set_err), 32'd1);
    chk("bad_mm_time", cur, hms(0, 0, 0));
    step();

    // Set applied in the same cycle as a tick: tick is dropped but still pulses.
    t0 = tick_cnt;
    sec_in = 1'b1;
    step();
    set_hh = 5'd10; set_mm = 6'd20; set_ss = 6'd30; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
    chk("set_vs_tick", cur, hms(10, 20, 30));
    step(2);
    chk("set_vs_tick_hold", cur, hms(10, 20, 30));
    chk("set_vs_tick_pulse", 32'(tick_cnt - t0), 32'd1);
    sec_in = 1'b0;
    step(4);

    // Setting straight onto the alarm time must not ring.
    alarm_hh = 5'd7; alarm_mm = 6'd0; alarm_en = 1'b1;
    set_time(7, 0, 0);
    step();
    chk("set_no_alarm", 32'(alarm_out), 32'd0);
    sec_pulse();
    chk("set_no_alarm_tick", 32'(alarm_out), 32'd0);

    // Alarm match and auto-stop after 60 seconds.
    set_time(6, 59, 59);
    chk("pre_alarm", 32'(alarm_out), 32'd0);
    sec_in = 1'b1;
    step(2);
    chk("alarm_before_edge", 32'(alarm_out), 32'd0);
    step();
    chk("alarm_rise", 32'(alarm_out), 32'd1);
    chk("alarm_time", cur, hms(7, 0, 0));
    step();
    sec_in = 1'b0;
    step(4);
    pulses(59);
    chk("ring_59", 32'(alarm_out), 32'd1);
    sec_pulse();
    chk("ring_timeout", 32'(alarm_out), 32'd0);
    chk("ring_timeout_time", cur, hms(7, 1, 0));
    sec_pulse();
    chk("idle_after_timeout", 32'(alarm_out), 32'd0);

    // Snooze, re-ring after 300 s, ring counter restarted.
    set_time(6, 59, 59);
    sec_pulse();
    chk("ring2", 32'(alarm_out), 32'd1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snooze_off", 32'(alarm_out), 32'd0);
    pulses(299);
    chk("snooze_299", 32'(alarm_out), 32'd0);
    sec_pulse();
    chk("snooze_ring", 32'(alarm_out), 32'd1);
    pulses(59);
    chk("ring_restart_59", 32'(alarm_out), 32'd1);
    sec_pulse();
    chk("ring_restart_stop", 32'(alarm_out), 32'd0);

    // ack and snooze together: ack wins, no re-ring later.
    set_time(6, 59, 59);
    sec_pulse();
    chk("ring3", 32'(alarm_out), 32'd1);
    alarm_ack = 1'b1; snooze = 1'b1;
    step();
    alarm_ack = 1'b0; snooze = 1'b0;
    chk("ack_snooze_off", 32'(alarm_out), 32'd0);
    pulses(300);
    chk("ack_wins", 32'(alarm_out), 32'd0);

    // Disarming while ringing.
    set_time(6, 59, 59);
    sec_pulse();
    chk("ring4", 32'(alarm_out), 32'd1);
    alarm_en = 1'b0;
    step();
    chk("disarm", 32'(alarm_out), 32'd0);
    alarm_en = 1'b1;
    step();
    chk("rearm_idle", 32'(alarm_out), 32'd0);

    // Reset mid-ring with sec_in held high.
    set_time(6, 59, 59);
    sec_pulse();
    chk("ring5", 32'(alarm_out), 32'd1);
    sec_in = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("rst_ring_alarm", 32'(alarm_out), 32'd0);
    chk("rst_ring_time",  cur, 32'd0);
    chk("rst_ring_tick",  32'(tick), 32'd0);
    step(3);
    rst = 1'b0;
    t0 = tick_cnt;
    step(6);
    chk("rst_one_tick", 32'(tick_cnt - t0), 32'd1);
    chk("rst_one_tick_time", cur, hms(0, 0, 1));
    chk("rst_release_alarm", 32'(alarm_out), 32'd0);
    sec_in = 1'b0;
    step(4);
    chk("rst_fall_ignored", 32'(tick_cnt - t0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
